uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receive stage of the UART link; consumes the `tx` line driven by the transmit side and produces parallel bytes on `doutrx` with a `donerx` strobe.
- Frame format: 8N1, LSB first, idle-high line.
- Single clock domain; the asynchronous serial input is synchronised internally.
- Sits directly downstream of the transmitter; its outputs feed the consumer side of the UART interface.

Parameters:
- clk_rate, 1000000, system clock frequency in Hz.
- baud_rate, 9600, line bit rate in bits/s.
- CLKS_PER_BIT (localparam) = clk_rate/baud_rate, integer division; 104 at defaults.
- HALF_BIT (localparam) = CLKS_PER_BIT/2; 52 at defaults.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, asynchronous to clk; idle high.
- doutrx  output  8  last correctly received byte.
- donerx  output  1  one-cycle pulse when `doutrx` is updated.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  output  1  one-cycle parity-error pulse; constant 0 unless UART_RX_PARITY_EN is defined.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; bit counter and baud counter = 0; shift register = 0.
  - `doutrx`=8'h00, `donerx`=0, `frame_err`=0, `parity_err`=0.
  - Both synchroniser flops reset to 1, so no false start is seen on reset release.
- Synchroniser: two flops on `rx`; all decisions use the second flop (rx_s). This adds 2 cycles of latency.
- Baud counter: counts 0..limit-1. A sample is taken on the cycle it reaches limit-1, then the counter clears.
- IDLE:
  - Baud counter held at 0.
  - rx_s==0 -> START.
- START:
  - limit=HALF_BIT, then sample.
  - rx_s==0 -> DATA, bit counter=0.
  - rx_s==1 -> IDLE (glitch rejected). No pulses are issued.
- DATA:
  - limit=CLKS_PER_BIT per bit.
  - Each sample shifts into the MSB of the shift register (LSB-first reconstruction).
  - After the 8th sample (bit counter 7) -> STOP, or -> PARITY when parity is enabled.
- STOP:
  - limit=CLKS_PER_BIT, then sample.
  - rx_s==1: `doutrx` <= shift register and `donerx`=1 for exactly one cycle (the cycle after the sample), then -> IDLE.
  - rx_s==0: `frame_err`=1 for one cycle; `doutrx` is unchanged and `donerx` stays 0; then -> BREAK.
- BREAK: wait for rx_s==1, then -> IDLE. This prevents a held-low line from being decoded as repeated 0x00 frames.
- Outputs:
  - `donerx` and `frame_err` are never high in the same cycle.
  - `doutrx` is stable between `donerx` pulses.
- Latency: `donerx` rises 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the falling edge of `rx` (991 at defaults).
- Back-to-back frames: a new start bit arriving immediately after the stop-bit centre is accepted; IDLE is re-entered on the cycle after the stop sample.
- Reset mid-frame: the partial frame is discarded with no pulses. After release, reception resumes on the next falling edge.
- Baud rate: integer truncation error of CLKS_PER_BIT is not compensated. The integration owner ensures clk_rate/baud_rate >= 16.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1 (even parity).
  - PARITY state follows DATA with limit=CLKS_PER_BIT; the sample is compared against the XOR of the 8 data bits.
  - STOP then proceeds as normal.
  - Mismatch with a good stop bit: `parity_err`=1 for one cycle in the same cycle `donerx` would assert; `donerx` stays 0 and `doutrx` is not updated.
  - Latency increases by CLKS_PER_BIT.
- Undefined: no PARITY state, `parity_err` tied to 0, 8N1 only.

Test Plan:
- Send 0xA5 (8N1, 104 clk/bit) after reset -> single `donerx` pulse 991±2 cycles after the start edge, `doutrx`=8'hA5, `frame_err`=0.
- 20-cycle low glitch on `rx` -> FSM returns to IDLE; no `donerx`, `frame_err` or `parity_err` pulse.
- Send 0x3C with the stop bit forced low, hold `rx` low 500 cycles, release, then send 0x81 -> one `frame_err` pulse; `doutrx` stays at its previous value; then `donerx` with `doutrx`=8'h81.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three `donerx` pulses 1040 cycles apart carrying those values in order.
- Assert `rst` during bit 4 of 0x96, release, then send 0x42 -> outputs 0 during reset; no pulse for 0x96; `donerx` with `doutrx`=8'h42.
- With UART_RX_PARITY_EN: send 0x07 with parity 1 -> `donerx`, `doutrx`=8'h07. Send 0x07 with parity 0 -> `parity_err` pulse, no `donerx`, `doutrx` stays 8'h07.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART link: serial line in, received byte and status pulses out.
// dbg_state mirrors the receiver FSM state for checkers.
interface uart_rx_if;
    logic       rx;
    logic [7:0] doutrx;
    logic       donerx;
    logic       frame_err;
    logic       parity_err;
    logic [2:0] dbg_state;

    // Strobes are single-cycle; doutrx is only meaningful on and after a donerx pulse.
    modport master (
        input  rx,
        output doutrx, donerx, frame_err, parity_err, dbg_state
    );

    modport slave (
        output rx,
        input  doutrx, donerx, frame_err, parity_err, dbg_state
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB-first with mid-bit sampling; define UART_RX_PARITY_EN for 8E1
// (even parity) with a one-cycle parity_err pulse in place of donerx on a parity mismatch.
module uart_rx #(
    parameter int clk_rate  = 1000000,
    parameter int baud_rate = 9600
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.master bus
);
    localparam int CLKS_PER_BIT = clk_rate / baud_rate;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic          rx_m, rx_s;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          sample;
    logic          done_nxt, ferr_nxt, perr_nxt;
    logic [7:0]    dout_q;
    logic          done_q, ferr_q, perr_q;
`ifdef UART_RX_PARITY_EN
    logic          par_bad;
`endif

    // Synchroniser resets high so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

    assign sample = (state == S_START) ? (baud_cnt == HALF_LAST) : (baud_cnt == FULL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!rx_s) state_nxt = S_START;
            S_START: if (sample) state_nxt = rx_s ? S_IDLE : S_DATA;
            S_DATA: begin
                if (sample && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
            S_PARITY: if (sample) state_nxt = S_STOP;
            S_STOP:   if (sample) state_nxt = rx_s ? S_IDLE : S_BREAK;
            S_BREAK:  if (rx_s) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Status pulses are decided at the stop-bit sample and registered one cycle later.
    always_comb begin
        done_nxt = 1'b0;
        ferr_nxt = 1'b0;
        perr_nxt = 1'b0;
        if (state == S_STOP && sample) begin
            if (!rx_s) ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (par_bad) perr_nxt = 1'b1;
`endif
            else done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            dout_q   <= 8'h00;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            if (state == S_IDLE || state == S_BREAK || sample) baud_cnt <= '0;
            else                                               baud_cnt <= baud_cnt + 1'b1;

            if (state == S_START)            bit_cnt <= 3'd0;
            else if (state == S_DATA && sample) bit_cnt <= bit_cnt + 3'd1;

            // LSB arrives first, so shifting in at the top leaves bit 0 at the bottom.
            if (state == S_DATA && sample) shreg <= {rx_s, shreg[7:1]};

            if (done_nxt) dout_q <= shreg;
            done_q <= done_nxt;
            ferr_q <= ferr_nxt;
            perr_q <= perr_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              par_bad <= 1'b0;
        else if (state == S_START)            par_bad <= 1'b0;
        else if (state == S_PARITY && sample) par_bad <= rx_s ^ (^shreg);
    end
`endif

    assign bus.doutrx     = dout_q;
    assign bus.donerx     = done_q;
    assign bus.frame_err  = ferr_q;
    assign bus.parity_err = perr_q;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames checked against
// a frame-level model that predicts the ordered stream of status pulses.
module tb_uart_rx;
    localparam int CLK_RATE = 1000000;
    localparam int BAUD     = 9600;
    localparam int CPB      = CLK_RATE / BAUD;
    localparam int HALF     = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN   = 1'b1;
    localparam int NBITS    = 11;
`else
    localparam bit PAR_EN   = 1'b0;
    localparam int NBITS    = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;
    localparam int EXP_LAT   = 2 + HALF + (NBITS - 1) * CPB + 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_if bus ();
    uart_rx #(.clk_rate(CLK_RATE), .baud_rate(BAUD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // scoreboard state: token = {kind, doutrx}; kind 1=donerx, 2=frame_err, 3=parity_err
    int         n_vec = 0;
    int         n_err = 0;
    logic [9:0] exp_q[$];
    logic [7:0] ref_dout;
    int         last_fall;
    int         last_done_cyc;
    int         done_t[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Frame-level reference: what the receiver must report for one complete frame.
    task automatic model_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
        if (!stop_ok)              exp_q.push_back({2'd2, ref_dout});
        else if (PAR_EN && !par_ok) exp_q.push_back({2'd3, ref_dout});
        else begin
            ref_dout = d;
            exp_q.push_back({2'd1, d});
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [9:0] tok;
        if (!rst) begin
            if (bus.donerx && bus.frame_err) chk("done_with_ferr", 32'd1, 32'd0);
            tok = '0;
            if (bus.donerx)          tok = {2'd1, bus.doutrx};
            else if (bus.frame_err)  tok = {2'd2, bus.doutrx};
            else if (bus.parity_err) tok = {2'd3, bus.doutrx};
            if (tok != '0) begin
                if (bus.donerx) begin
                    last_done_cyc = cyc;
                    done_t.push_back(cyc);
                end
                if (exp_q.size() == 0) chk("unexpected_pulse", {22'd0, tok}, 32'd0);
                else                   chk("pulse", {22'd0, tok}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks: called and returning on a falling clock edge
    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        bus.rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
        model_frame(d, stop_ok, par_ok);
        last_fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par_ok ? ^d : ~^d);
        drive_bit(stop_ok);
    endtask

    task automatic check_quiet_reset(input string tag);
        chk({tag, "_dout"}, {24'd0, bus.doutrx}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.donerx}, 32'd0);
        chk({tag, "_ferr"}, {31'd0, bus.frame_err}, 32'd0);
        chk({tag, "_perr"}, {31'd0, bus.parity_err}, 32'd0);
        chk({tag, "_state"}, {29'd0, bus.dbg_state}, 32'd0);
    endtask

    initial begin
        int         lat;
        logic [7:0] d;
        logic [7:0] d96;
        logic       s_ok, p_ok;

        rst      = 1'b1;
        bus.rx   = 1'b1;
        ref_dout = 8'h00;
        repeat (5) @(negedge clk);
        check_quiet_reset("reset");
        rst = 1'b0;
        idle(20);

        // single frame and latency from the start edge
        last_done_cyc = -1;
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(10);
        lat = last_done_cyc - last_fall;
        chk("latency", (lat >= EXP_LAT - 2 && lat <= EXP_LAT + 2) ? 32'(EXP_LAT) : 32'(lat), 32'(EXP_LAT));
        chk("dout_a5", {24'd0, bus.doutrx}, 32'h0A5);
        chk("pending_a5", 32'(exp_q.size()), 32'd0);

        // short low glitch is rejected
        bus.rx = 1'b0;
        repeat (20) @(negedge clk);
        idle(200);
        chk("glitch_state", {29'd0, bus.dbg_state}, 32'd0);
        chk("glitch_dout", {24'd0, bus.doutrx}, 32'h0A5);

        // bad stop bit, line held low, then recovery
        send_frame(8'h3C, 1'b0, 1'b1);
        bus.rx = 1'b0;
        repeat (500) @(negedge clk);
        idle(50);
        chk("ferr_dout_held", {24'd0, bus.doutrx}, 32'h0A5);
        send_frame(8'h81, 1'b1, 1'b1);
        idle(10);
        chk("dout_81", {24'd0, bus.doutrx}, 32'h081);
        chk("pending_ferr", 32'(exp_q.size()), 32'd0);

        // back-to-back frames with no idle gap
        done_t.delete();
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1);
        idle(10);
        chk("b2b_count", 32'(done_t.size()), 32'd3);
        if (done_t.size() == 3) begin
            chk("b2b_gap1", 32'(done_t[1] - done_t[0]), 32'(FRAME_CYC));
            chk("b2b_gap2", 32'(done_t[2] - done_t[1]), 32'(FRAME_CYC));
        end
        chk("dout_55", {24'd0, bus.doutrx}, 32'h055);

        // reset in the middle of bit 4
        d96 = 8'h96;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d96[i]);
        bus.rx = d96[4];
        repeat (HALF) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet_reset("midreset");
        ref_dout = 8'h00;
        bus.rx   = 1'b1;
        rst      = 1'b0;
        idle(20);
        send_frame(8'h42, 1'b1, 1'b1);
        idle(10);
        chk("dout_42", {24'd0, bus.doutrx}, 32'h042);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        idle(10);
        chk("par_good_dout", {24'd0, bus.doutrx}, 32'h007);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(10);
        chk("par_bad_dout", {24'd0, bus.doutrx}, 32'h007);
        chk("pending_par", 32'(exp_q.size()), 32'd0);
`endif

        // random frames, occasional bad stop or parity, random idle gaps
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom_range(0, 255));
            s_ok = ($urandom_range(0, 7) != 0);
            p_ok = ($urandom_range(0, 7) != 0);
            send_frame(d, s_ok, p_ok);
            chk("rand_dout", {24'd0, bus.doutrx}, {24'd0, ref_dout});
            if (s_ok) idle($urandom_range(0, 40));
            else      idle($urandom_range(CPB, 2 * CPB));
        end

        idle(50);
        chk("final_pending", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
